// File: rtl/proc_pkg.sv
// Shared processor constants and types for the multiply/divide path.
// Opcode/ALU-op fields, rstatus index, exception codes, sequencer states.
package proc_pkg;

  localparam logic [4:0] OP_ALU     = 5'b00000;
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  localparam int RSTATUS_REG   = 30;
  localparam int MULT_EXC_CODE = 4;
  localparam int DIV_EXC_CODE  = 5;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_DONE
  } md_state_t;

endpackage

// File: rtl/multdiv_decode.sv
// Combinational mult/div detector for the DX instruction, shared with stall logic.
// Ports: ir (32b) in; is_mult, is_div, rd (5b) out.
module multdiv_decode (
  input  logic [31:0] ir,
  output logic        is_mult,
  output logic        is_div,
  output logic [4:0]  rd
);
  import proc_pkg::*;

  logic alu_op;
  logic unused_ir;

  assign alu_op  = (ir[31:27] == OP_ALU);
  assign is_mult = alu_op && (ir[6:2] == ALUOP_MULT);
  assign is_div  = alu_op && (ir[6:2] == ALUOP_DIV);
  assign rd      = ir[26:22];

  assign unused_ir = ^{ir[21:7], ir[1:0]};

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues mult/div from DX to the iterative unit, stalls the front end, writes back once.
// Ports: clock, global_reset, dx_ir/dx_a/dx_b, flush, unit_ready/result/exception in;
//   ctrl_mult/ctrl_div, unit_a/unit_b, md_stall, wb_valid/wb_rd/wb_data, busy out.
// Optional RUN timeout: define MULTDIV_TIMEOUT_EN.
module multdiv_sequencer #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int RSTATUS_REG    = proc_pkg::RSTATUS_REG,
  parameter int MULT_EXC_CODE  = proc_pkg::MULT_EXC_CODE,
  parameter int DIV_EXC_CODE   = proc_pkg::DIV_EXC_CODE,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic              clock,
  input  logic              global_reset,
  input  logic [31:0]       dx_ir,
  input  logic [DATA_W-1:0] dx_a,
  input  logic [DATA_W-1:0] dx_b,
  input  logic              flush,
  input  logic              unit_ready,
  input  logic [DATA_W-1:0] unit_result,
  input  logic              unit_exception,
  output logic              ctrl_mult,
  output logic              ctrl_div,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  output logic              md_stall,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);
  import proc_pkg::*;

  localparam logic [REG_W-1:0]  RS_IDX   = REG_W'(RSTATUS_REG);
  localparam logic [DATA_W-1:0] MULT_EXC = DATA_W'(MULT_EXC_CODE);
  localparam logic [DATA_W-1:0] DIV_EXC  = DATA_W'(DIV_EXC_CODE);

  md_state_t state, state_n;

  logic              is_mult, is_div;
  logic [4:0]        dec_rd;
  logic              issue;

  logic [REG_W-1:0]  rd_q, rd_n;
  logic              div_q, div_n;
  logic [DATA_W-1:0] ua_n, ub_n;
  logic              cm_n, cd_n;
  logic              wv_n;
  logic [REG_W-1:0]  wrd_n;
  logic [DATA_W-1:0] wd_n;
  logic [DATA_W-1:0] exc_data;
  logic              ready_ok;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_n;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  multdiv_decode u_decode (
    .ir      (dx_ir),
    .is_mult (is_mult),
    .is_div  (is_div),
    .rd      (dec_rd)
  );

  assign issue    = (is_mult || is_div) && !flush;
  assign exc_data = div_q ? DIV_EXC : MULT_EXC;
  // The unit cannot answer in the cycle its start pulse is visible.
  assign ready_ok = unit_ready && !(ctrl_mult || ctrl_div);

  always_comb begin
    state_n  = state;
    rd_n     = rd_q;
    div_n    = div_q;
    ua_n     = unit_a;
    ub_n     = unit_b;
    cm_n     = 1'b0;
    cd_n     = 1'b0;
    wv_n     = 1'b0;
    wrd_n    = wb_rd;
    wd_n     = wb_data;
    md_stall = 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
    cnt_n    = cnt_q;
`endif
    unique case (state)
      MD_IDLE: begin
        if (issue) begin
          md_stall = 1'b1;
          ua_n     = dx_a;
          ub_n     = dx_b;
          rd_n     = REG_W'(dec_rd);
          div_n    = is_div;
`ifdef MULTDIV_TIMEOUT_EN
          cnt_n    = '0;
`endif
          // Divide by zero is resolved here; the unit never sees it.
          if (is_div && dx_b == '0) begin
            state_n = MD_DONE;
            wv_n    = 1'b1;
            wrd_n   = RS_IDX;
            wd_n    = DIV_EXC;
          end else begin
            state_n = MD_RUN;
            cm_n    = is_mult;
            cd_n    = is_div;
          end
        end
      end
      MD_RUN: begin
        md_stall = 1'b1;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_n    = cnt_q + 1'b1;
`endif
        if (flush) begin
          state_n = MD_IDLE;
        end else if (ready_ok) begin
          state_n = MD_DONE;
          wv_n    = 1'b1;
          wrd_n   = unit_exception ? RS_IDX : rd_q;
          wd_n    = unit_exception ? exc_data : unit_result;
        end
`ifdef MULTDIV_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_n = MD_DONE;
          wv_n    = 1'b1;
          wrd_n   = RS_IDX;
          wd_n    = exc_data;
        end
`endif
      end
      MD_DONE: begin
        state_n = MD_IDLE;
      end
      default: begin
        state_n = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      state     <= MD_IDLE;
      rd_q      <= '0;
      div_q     <= 1'b0;
      unit_a    <= '0;
      unit_b    <= '0;
      ctrl_mult <= 1'b0;
      ctrl_div  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      busy      <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state     <= state_n;
      rd_q      <= rd_n;
      div_q     <= div_n;
      unit_a    <= ua_n;
      unit_b    <= ub_n;
      ctrl_mult <= cm_n;
      ctrl_div  <= cd_n;
      wb_valid  <= wv_n;
      wb_rd     <= wrd_n;
      wb_data   <= wd_n;
      busy      <= (state_n != MD_IDLE);
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q     <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: vector table plus corner sequences.
// Writebacks are checked against a scoreboard queue filled at issue time.
module tb_multdiv_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        global_reset;
  logic [31:0] dx_ir, dx_a, dx_b;
  logic        flush;
  logic        unit_ready;
  logic [31:0] unit_result;
  logic        unit_exception;
  logic        ctrl_mult, ctrl_div;
  logic [31:0] unit_a, unit_b;
  logic        md_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  multdiv_sequencer dut (
    .clock          (clock),
    .global_reset   (global_reset),
    .dx_ir          (dx_ir),
    .dx_a           (dx_a),
    .dx_b           (dx_b),
    .flush          (flush),
    .unit_ready     (unit_ready),
    .unit_result    (unit_result),
    .unit_exception (unit_exception),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .unit_a         (unit_a),
    .unit_b         (unit_b),
    .md_stall       (md_stall),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int wb_count = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t sb[$];

  typedef struct {
    bit          div;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          lat;
    bit          exc;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int          exp_m;
    int          exp_d;
    int          exp_stall;
    int          exp_wb;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input bit d, input logic [4:0] rd);
    logic [4:0] op;
    op = d ? 5'b00111 : 5'b00110;
    return {5'b00000, rd, 15'h0A5A, op, 2'b11};
  endfunction

  always @(negedge clock) begin
    wb_t e;
    if (wb_valid) begin
      wb_count++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected rd=%0d data=%0d required=none",
                 wb_rd, wb_data);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic run_op(input vec_t v, input int idx);
    int nm = 0;
    int nd = 0;
    int ns = 0;
    int wbc = -1;
    int p = -1;
    wb_t e;
    @(posedge clock); #1;
    dx_ir = mk_ir(v.div, v.rd);
    dx_a  = v.a;
    dx_b  = v.b;
    e.rd  = v.exp_rd;
    e.data = v.exp_data;
    sb.push_back(e);
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      unit_ready = 1'b0;
      unit_exception = 1'b0;
      if (c == 0) chk($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 0);
      if (ctrl_mult) nm++;
      if (ctrl_div) nd++;
      if (ctrl_mult || ctrl_div) p = c;
      if (md_stall) ns++;
      if (wb_valid) begin
        wbc = c;
        break;
      end
      if (p >= 0 && c == p + v.lat) begin
        unit_ready = 1'b1;
        unit_result = v.div ? v.a / v.b : v.a * v.b;
        unit_exception = v.exc;
      end
    end
    chk($sformatf("v%0d_mult_pulses", idx), nm, v.exp_m);
    chk($sformatf("v%0d_div_pulses", idx), nd, v.exp_d);
    chk($sformatf("v%0d_stall_cycles", idx), ns, v.exp_stall);
    chk($sformatf("v%0d_wb_cycle", idx), wbc, v.exp_wb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int ns;
    int c;
    wb_t e;
    global_reset = 1'b1;
    dx_ir = NOP;
    dx_a = '0;
    dx_b = '0;
    flush = 1'b0;
    unit_ready = 1'b0;
    unit_result = '0;
    unit_exception = 1'b0;

    vt[0] = '{0, 6, 7, 5, 32, 0, 5, 42, 1, 0, 34, 34};
    vt[1] = '{1, 20, 4, 7, 3, 0, 7, 5, 0, 1, 5, 5};
    vt[2] = '{1, 9, 0, 8, 0, 0, 30, 5, 0, 0, 1, 1};
    vt[3] = '{0, 123456, 789, 9, 4, 1, 30, 4, 1, 0, 6, 6};
    vt[4] = '{1, 50, 3, 3, 2, 1, 30, 5, 0, 1, 4, 4};
    vt[5] = '{0, 3, 5, 0, 1, 0, 0, 15, 1, 0, 3, 3};
    vt[6] = '{1, 100, 7, 31, 1, 0, 31, 14, 0, 1, 3, 3};
    vt[7] = '{1, 20, 4, 10, 2, 0, 10, 5, 0, 1, 4, 4};
    vt[8] = '{1, 9, 3, 11, 2, 0, 11, 3, 0, 1, 4, 4};

    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_ctrl", {30'd0, ctrl_mult, ctrl_div}, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_stall", {31'd0, md_stall}, 0);
    global_reset = 1'b0;

    for (int i = 0; i < 9; i++) run_op(vt[i], i);
    @(posedge clock); #1;
    dx_ir = NOP;

    // Ready during the start pulse must be ignored.
    @(posedge clock); #1;
    dx_ir = mk_ir(0, 12);
    dx_a = 2;
    dx_b = 3;
    e.rd = 12;
    e.data = 99;
    sb.push_back(e);
    @(negedge clock);
    @(negedge clock);
    chk("early_pulse", {31'd0, ctrl_mult}, 1);
    unit_ready = 1'b1;
    unit_result = 77;
    @(negedge clock);
    unit_ready = 1'b0;
    chk("early_no_wb", {31'd0, wb_valid}, 0);
    chk("early_busy", {31'd0, busy}, 1);
    unit_ready = 1'b1;
    unit_result = 99;
    @(negedge clock);
    unit_ready = 1'b0;
    chk("early_wb", {31'd0, wb_valid}, 1);
    dx_ir = NOP;

    // Flush in the issue cycle blocks issue.
    @(posedge clock); #1;
    dx_ir = mk_ir(0, 13);
    flush = 1'b1;
    #1;
    chk("flush_issue_stall", {31'd0, md_stall}, 0);
    @(posedge clock); #1;
    flush = 1'b0;
    dx_ir = NOP;
    @(negedge clock);
    chk("flush_issue_ctrl", {31'd0, ctrl_mult}, 0);
    chk("flush_issue_busy", {31'd0, busy}, 0);

    // Flush in RUN abandons the op; the late ready is stray.
    w0 = wb_count;
    @(posedge clock); #1;
    dx_ir = mk_ir(0, 14);
    dx_a = 1;
    dx_b = 1;
    repeat (7) @(negedge clock);
    chk("flush_run_busy", {31'd0, busy}, 1);
    chk("flush_run_stall", {31'd0, md_stall}, 1);
    flush = 1'b1;
    dx_ir = NOP;
    @(negedge clock);
    flush = 1'b0;
    chk("flush_run_idle", {31'd0, busy}, 0);
    chk("flush_run_unstall", {31'd0, md_stall}, 0);
    unit_ready = 1'b1;
    unit_result = 55;
    @(negedge clock);
    unit_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("flush_run_no_wb", wb_count, w0);
    chk("stray_ready_busy", {31'd0, busy}, 0);

    // Flush while in DONE still lets the writeback through.
    @(posedge clock); #1;
    dx_ir = mk_ir(1, 15);
    dx_a = 9;
    dx_b = 0;
    e.rd = 30;
    e.data = 5;
    sb.push_back(e);
    @(negedge clock);
    chk("div0_stall", {31'd0, md_stall}, 1);
    chk("div0_no_pulse_issue", {31'd0, ctrl_div}, 0);
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    chk("flush_done_wb", {31'd0, wb_valid}, 1);
    chk("div0_no_pulse", {31'd0, ctrl_div}, 0);
    flush = 1'b0;
    dx_ir = NOP;
    @(negedge clock);
    chk("flush_done_idle", {31'd0, busy}, 0);

    // Reset in the middle of RUN.
    w0 = wb_count;
    @(posedge clock); #1;
    dx_ir = mk_ir(0, 16);
    dx_a = 5;
    dx_b = 6;
    repeat (4) @(negedge clock);
    chk("mid_unit_a", unit_a, 5);
    global_reset = 1'b1;
    dx_ir = NOP;
    @(negedge clock);
    global_reset = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_ctrl", {30'd0, ctrl_mult, ctrl_div}, 0);
    chk("mid_rst_wb", {26'd0, wb_valid, wb_rd}, 0);
    chk("mid_rst_wb_data", wb_data, 0);
    chk("mid_rst_unit", unit_a | unit_b, 0);
    chk("mid_rst_stall", {31'd0, md_stall}, 0);
    unit_ready = 1'b1;
    unit_result = 30;
    @(negedge clock);
    unit_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_rst_no_wb", wb_count, w0);

`ifdef MULTDIV_TIMEOUT_EN
    @(posedge clock); #1;
    dx_ir = mk_ir(0, 17);
    dx_a = 3;
    dx_b = 3;
    e.rd = 30;
    e.data = 4;
    sb.push_back(e);
    c = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (wb_valid) begin
        c = k;
        break;
      end
    end
    chk("timeout_window", {31'd0, (c >= 40 && c <= 44)}, 1);
    @(posedge clock); #1;
    dx_ir = NOP;
    @(negedge clock);
    chk("timeout_idle", {31'd0, busy}, 0);
`else
    w0 = wb_count;
    ns = 0;
    @(posedge clock); #1;
    dx_ir = mk_ir(0, 17);
    dx_a = 3;
    dx_b = 3;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (md_stall) ns++;
    end
    chk("no_timeout_stall", ns, 100);
    chk("no_timeout_no_wb", wb_count, w0);
    flush = 1'b1;
    dx_ir = NOP;
    @(negedge clock);
    flush = 1'b0;
    chk("no_timeout_flush", {31'd0, busy}, 0);
    c = 0;
`endif

    repeat (2) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Owns the iterative multiply/divide unit in the 5-stage pipeline.
- Detects a mult/div instruction in the DX latch, then:
  - latches its operands and destination;
  - pulses the unit's start control;
  - holds the front-end stall until the unit reports ready.
- Presents one writeback beat per operation (result or rstatus exception code), plus a clean abort on pipeline flush.
- Replaces the ad-hoc busy flop inside the stall logic; the stall logic ORs in `md_stall`.

Parameters:
- DATA_W, 32, operand/result width.
- REG_W, 5, register-index width.
- RSTATUS_REG, 30, destination register for exception codes.
- MULT_EXC_CODE, 4, rstatus value on multiply overflow.
- DIV_EXC_CODE, 5, rstatus value on divide-by-zero or divide exception.
- TIMEOUT_CYCLES, 40, RUN-cycle limit (only with the optional feature).

Ports:
- clock  in  1  system clock; all state on rising edge.
- global_reset  in  1  synchronous, active-high reset.
- dx_ir  in  32  instruction in the DX latch.
- dx_a  in  DATA_W  rs operand after bypass.
- dx_b  in  DATA_W  rt operand after bypass.
- flush  in  1  branch/jump squash of DX and younger.
- unit_ready  in  1  unit result valid (1-cycle pulse).
- unit_result  in  DATA_W  unit result.
- unit_exception  in  1  unit overflow/div-zero flag, valid with unit_ready.
- ctrl_mult  out  1  start-multiply pulse to unit.
- ctrl_div  out  1  start-divide pulse to unit.
- unit_a  out  DATA_W  latched operand A.
- unit_b  out  DATA_W  latched operand B.
- md_stall  out  1  freeze PC/FD/DX.
- wb_valid  out  1  writeback beat.
- wb_rd  out  REG_W  writeback destination.
- wb_data  out  DATA_W  writeback data.
- busy  out  1  operation outstanding (state != IDLE).

Behaviour:
- Decode: the instruction is a mult/div when `dx_ir[31:27]==5'b00000` and `dx_ir[6:2]` is `00110` (mult) or `00111` (div). Destination is `dx_ir[26:22]`.
- States: IDLE, RUN, DONE. All registered outputs reset to 0 and the state resets to IDLE; reset mid-operation abandons the operation with no wb_valid.
- IDLE:
  - If mult/div is decoded and `!flush`: latch dx_a/dx_b into unit_a/unit_b, latch rd and op, assert ctrl_mult or ctrl_div for exactly the next cycle, then go to RUN.
  - md_stall is asserted combinationally in this issue cycle.
  - Div with `dx_b==0`: skip the unit (no ctrl pulse), go directly to DONE with the exception result.
- RUN:
  - md_stall=1.
  - On unit_ready go to DONE, capturing unit_result/unit_exception.
  - unit_ready in the same cycle as the start pulse is ignored; minimum RUN length is 1 cycle after the pulse.
- DONE:
  - wb_valid=1 for exactly one cycle, then IDLE; md_stall=0, so DX advances at this edge.
  - No exception: wb_rd=latched rd, wb_data=result.
  - Exception: wb_rd=RSTATUS_REG, wb_data=MULT_EXC_CODE or DIV_EXC_CODE.
- Re-issue guard: no issue is possible from DONE, so the same DX instruction is never issued twice. Back-to-back mult/div cost one IDLE cycle between them.
- flush:
  - In issue cycle: no issue.
  - In RUN: return to IDLE, suppress wb; a later stray unit_ready in IDLE is ignored.
  - In DONE: wb still fires, since the instruction is older than the squash.
- wb_rd=0 with no exception: wb_valid is still asserted; the regfile discards writes to r0.
- Timing: ctrl_* pulses, wb_*, unit_a/b and busy are registered; md_stall is combinational from state + decode.

Optional Feature:
- Macro: MULTDIV_TIMEOUT_EN.
- Defined: a counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on issue and increments in RUN. When it reaches TIMEOUT_CYCLES with no unit_ready, go to DONE with an exception: wb_rd=RSTATUS_REG, wb_data=DIV_EXC_CODE for div or MULT_EXC_CODE for mult. Any later unit_ready is ignored.
- Undefined: no counter; RUN waits indefinitely.

Decomposition:
- Shared package `proc_pkg`:
  - opcode/ALU-op constants (OP_ALU=5'b00000, ALUOP_MULT=5'b00110, ALUOP_DIV=5'b00111);
  - RSTATUS_REG;
  - exception codes;
  - state enum `md_state_t`.
- One sub-module, `multdiv_decode`: combinational, dx_ir -> {is_mult, is_div, rd}. It is shared with the stall logic.

Test Plan:
- mult, dx_a=6, dx_b=7, unit_ready 32 cycles after pulse with result 42 -> ctrl_mult one cycle; md_stall held through RUN; single wb_valid, wb_rd=dx_ir[26:22], wb_data=42.
- div, dx_b=0 -> no ctrl_div; DONE next cycle; wb_rd=30, wb_data=5; total stall 1 cycle.
- mult with unit_exception=1 on ready -> wb_rd=30, wb_data=4.
- flush 5 cycles into RUN, then unit_ready arrives -> state IDLE, no wb_valid ever; the stray ready causes no output.
- Two consecutive div (20/4 then 9/3) -> two separate ctrl_div pulses, wb_data 5 then 3, one IDLE cycle between.
- global_reset asserted mid-RUN -> next cycle all outputs 0, IDLE.
- With MULTDIV_TIMEOUT_EN and no ready -> wb after TIMEOUT_CYCLES with rstatus code; without the macro, md_stall persists indefinitely.
